// File: rtl/soc_ahb3_pkg.sv
// Shared AHB3-Lite encodings and a helper used by the bus arbiter.
package soc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // True while a master is inside a multi-beat burst: the opening NONSEQ
  // of an INCR/WRAP burst, any SEQ beat, or a BUSY pause.
  function automatic logic in_burst(input logic [1:0] htrans, input logic [2:0] hburst);
    return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY) ||
           ((htrans == HTRANS_NONSEQ) && (hburst != HBURST_SINGLE));
  endfunction

endpackage

// File: rtl/soc_rr_arbiter_ahb3.sv
// Combinational round-robin picker: first requester at or after ptr_i.
module soc_rr_arbiter_ahb3 #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

  // Scan farthest-to-nearest so the candidate closest to the pointer is written last and wins.
  always_comb begin
    int pos;
    gnt_o = '0;
    idx_o = '0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(ptr_i) + k) % N;
      if (en_i && req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = W'(pos);
      end
    end
  end

endmodule

// File: rtl/soc_arbiter_ahb3.sv
// AHB3-Lite multi-master arbiter: round-robin grant with burst/lock hold,
// address-phase mux and data-phase owner tracking for HWDATA/HRESP routing.
module soc_arbiter_ahb3 import soc_ahb3_pkg::*; #(
  parameter int MASTERS = 2,
  parameter int XLEN    = 32,
  parameter int PLEN    = 32,
  localparam int SW     = XLEN >> 3,
  localparam int MW     = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [MASTERS-1:0]      m_hsel_i,
  input  logic [MASTERS*PLEN-1:0] m_haddr_i,
  input  logic [MASTERS*XLEN-1:0] m_hwdata_i,
  input  logic [MASTERS-1:0]      m_hwrite_i,
  input  logic [MASTERS*3-1:0]    m_hsize_i,
  input  logic [MASTERS*3-1:0]    m_hburst_i,
  input  logic [MASTERS*SW-1:0]   m_hprot_i,
  input  logic [MASTERS*2-1:0]    m_htrans_i,
  input  logic [MASTERS-1:0]      m_hmastlock_i,
  output logic [MASTERS*XLEN-1:0] m_hrdata_o,
  output logic [MASTERS-1:0]      m_hready_o,
  output logic [MASTERS-1:0]      m_hresp_o,
  output logic                    s_hsel_o,
  output logic [PLEN-1:0]         s_haddr_o,
  output logic [XLEN-1:0]         s_hwdata_o,
  output logic                    s_hwrite_o,
  output logic [2:0]              s_hsize_o,
  output logic [2:0]              s_hburst_o,
  output logic [SW-1:0]           s_hprot_o,
  output logic [1:0]              s_htrans_o,
  output logic                    s_hmastlock_o,
  input  logic [XLEN-1:0]         s_hrdata_i,
  input  logic                    s_hready_i,
  input  logic                    s_hresp_i
);

  logic [MW-1:0] grant_q, grant_d, downer_q, downer_d, rr_ptr_q, rr_ptr_d;
  logic          gvalid_q, gvalid_d, dvalid_q, dvalid_d, lock_q, lock_d;

  logic [PLEN-1:0] haddr_a     [MASTERS];
  logic [XLEN-1:0] hwdata_a    [MASTERS];
  logic [2:0]      hsize_a     [MASTERS];
  logic [2:0]      hburst_a    [MASTERS];
  logic [SW-1:0]   hprot_a     [MASTERS];
  logic [1:0]      htrans_a    [MASTERS];
  logic [MASTERS-1:0] req;

  logic [MASTERS-1:0] win_onehot;
  logic [MW-1:0]      win_idx;
  logic               win_valid;
  logic               hold;
  logic               xfer;

  for (genvar gi = 0; gi < MASTERS; gi++) begin : g_master
    assign haddr_a[gi]  = m_haddr_i[gi*PLEN +: PLEN];
    assign hwdata_a[gi] = m_hwdata_i[gi*XLEN +: XLEN];
    assign hsize_a[gi]  = m_hsize_i[gi*3 +: 3];
    assign hburst_a[gi] = m_hburst_i[gi*3 +: 3];
    assign hprot_a[gi]  = m_hprot_i[gi*SW +: SW];
    assign htrans_a[gi] = m_htrans_i[gi*2 +: 2];
    assign req[gi]      = m_hsel_i[gi] & m_htrans_i[gi*2+1];

    // The address-phase owner and the data-phase owner follow the slave; anyone else waiting is stalled.
    assign m_hready_o[gi] = ((gvalid_q && (grant_q == MW'(gi))) || (dvalid_q && (downer_q == MW'(gi))))
                            ? s_hready_i : ~req[gi];
    assign m_hresp_o[gi]  = s_hresp_i & dvalid_q & (downer_q == MW'(gi));
    assign m_hrdata_o[gi*XLEN +: XLEN] = s_hrdata_i;
  end

  // Address fields of the granted master go straight through; control is masked when nobody is granted.
  always_comb begin
    s_haddr_o     = haddr_a[grant_q];
    s_hwrite_o    = m_hwrite_i[grant_q];
    s_hsize_o     = hsize_a[grant_q];
    s_hburst_o    = hburst_a[grant_q];
    s_hprot_o     = hprot_a[grant_q];
    s_hsel_o      = gvalid_q & m_hsel_i[grant_q];
    s_htrans_o    = gvalid_q ? htrans_a[grant_q] : HTRANS_IDLE;
    s_hmastlock_o = gvalid_q & m_hmastlock_i[grant_q];
    s_hwdata_o    = hwdata_a[downer_q];
  end

  // An ERROR response releases the hold so the bus can be re-arbitrated on its second cycle.
  assign hold = gvalid_q & ~(s_hresp_i & dvalid_q) &
                (in_burst(htrans_a[grant_q], hburst_a[grant_q]) | m_hmastlock_i[grant_q] | lock_q);
  assign xfer = s_hsel_o & s_htrans_o[1];
  assign win_valid = |win_onehot;

  soc_rr_arbiter_ahb3 #(
    .N (MASTERS),
    .W (MW)
  ) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .en_i  (s_hready_i & ~hold),
    .gnt_o (win_onehot),
    .idx_o (win_idx)
  );

  // Next-state: data-owner capture, lock tracking and (re)arbitration, all gated by slave ready.
  always_comb begin
    grant_d  = grant_q;
    gvalid_d = gvalid_q;
    downer_d = downer_q;
    dvalid_d = dvalid_q;
    rr_ptr_d = rr_ptr_q;
    lock_d   = lock_q;
    if (s_hready_i) begin
      dvalid_d = xfer;
      if (xfer) begin
        downer_d = grant_q;
      end
      lock_d = gvalid_q & m_hmastlock_i[grant_q];
      if (!hold) begin
        if (MASTERS == 1) begin
          gvalid_d = 1'b1;
          grant_d  = '0;
        end else begin
          gvalid_d = win_valid;
          if (win_valid) begin
            grant_d  = win_idx;
            rr_ptr_d = (win_idx == MW'(MASTERS - 1)) ? '0 : win_idx + 1'b1;
          end
        end
      end
    end
  end

  // State registers; reset clears grant and data ownership at once so the slave sees IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q  <= '0;
      gvalid_q <= 1'b0;
      downer_q <= '0;
      dvalid_q <= 1'b0;
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      gvalid_q <= gvalid_d;
      downer_q <= downer_d;
      dvalid_q <= dvalid_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
    end
  end

endmodule

// File: tb/tb_soc_arbiter_ahb3.sv
// Bench for soc_arbiter_ahb3 (2 masters): directed scenarios then random traffic,
// every cycle compared against a cycle-level reference model of the arbitration rules.
module tb_soc_arbiter_ahb3;

  localparam int NM = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic        a_sel   [NM];
  logic [1:0]  a_trans [NM];
  logic [2:0]  a_burst [NM];
  logic [2:0]  a_size  [NM];
  logic [3:0]  a_prot  [NM];
  logic        a_lock  [NM];
  logic        a_write [NM];
  logic [31:0] a_addr  [NM];
  logic [31:0] a_wdata [NM];
  logic        s_ready, s_resp;
  logic [31:0] s_rdata;

  logic [63:0] m_hrdata;
  logic [1:0]  m_hready, m_hresp;
  logic        s_hsel, s_hwrite, s_hmastlock;
  logic [31:0] s_haddr, s_hwdata;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  int total = 0;
  int bad = 0;

  // reference model state
  int mg, mgv, md, mdv, mrr, mlk;

  soc_arbiter_ahb3 #(.MASTERS(2), .XLEN(32), .PLEN(32)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .m_hsel_i      ({a_sel[1], a_sel[0]}),
    .m_haddr_i     ({a_addr[1], a_addr[0]}),
    .m_hwdata_i    ({a_wdata[1], a_wdata[0]}),
    .m_hwrite_i    ({a_write[1], a_write[0]}),
    .m_hsize_i     ({a_size[1], a_size[0]}),
    .m_hburst_i    ({a_burst[1], a_burst[0]}),
    .m_hprot_i     ({a_prot[1], a_prot[0]}),
    .m_htrans_i    ({a_trans[1], a_trans[0]}),
    .m_hmastlock_i ({a_lock[1], a_lock[0]}),
    .m_hrdata_o    (m_hrdata),
    .m_hready_o    (m_hready),
    .m_hresp_o     (m_hresp),
    .s_hsel_o      (s_hsel),
    .s_haddr_o     (s_haddr),
    .s_hwdata_o    (s_hwdata),
    .s_hwrite_o    (s_hwrite),
    .s_hsize_o     (s_hsize),
    .s_hburst_o    (s_hburst),
    .s_hprot_o     (s_hprot),
    .s_htrans_o    (s_htrans),
    .s_hmastlock_o (s_hmastlock),
    .s_hrdata_i    (s_rdata),
    .s_hready_i    (s_ready),
    .s_hresp_i     (s_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wants(int i);
    return a_sel[i] && a_trans[i][1];
  endfunction

  task automatic model_reset();
    mg = 0; mgv = 0; md = 0; mdv = 0; mrr = 0; mlk = 0;
  endtask

  task automatic set_m(input int i, input bit sel, input logic [1:0] tr, input logic [2:0] bu,
                       input bit lk, input bit wr, input logic [31:0] ad, input logic [31:0] wd);
    a_sel[i] = sel; a_trans[i] = tr; a_burst[i] = bu; a_lock[i] = lk;
    a_write[i] = wr; a_addr[i] = ad; a_wdata[i] = wd; a_size[i] = 3'b010; a_prot[i] = 4'h3;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    s_ready = 1'b1; s_resp = 1'b0; s_rdata = 32'h0;
  endtask

  // Compare every DUT output against the model for the current cycle (mid-cycle sample).
  task automatic settle();
    logic [1:0] er, ep;
    #3;
    chk("s_hsel", s_hsel, mgv ? a_sel[mg] : 1'b0);
    chk("s_htrans", s_htrans, mgv ? a_trans[mg] : 2'b00);
    chk("s_hmastlock", s_hmastlock, mgv ? a_lock[mg] : 1'b0);
    if (mgv) begin
      chk("s_haddr", s_haddr, a_addr[mg]);
      chk("s_hwrite", s_hwrite, a_write[mg]);
      chk("s_hburst", s_hburst, a_burst[mg]);
      chk("s_hsize", s_hsize, a_size[mg]);
      chk("s_hprot", s_hprot, a_prot[mg]);
    end
    if (mdv) chk("s_hwdata", s_hwdata, a_wdata[md]);
    for (int i = 0; i < NM; i++) begin
      er[i] = ((mgv && mg == i) || (mdv && md == i)) ? s_ready : !wants(i);
      ep[i] = s_resp && mdv && (md == i);
    end
    chk("m_hready", m_hready, er);
    chk("m_hresp", m_hresp, ep);
    chk("m_hrdata1", m_hrdata[63:32], s_rdata);
  endtask

  // Advance one clock; the model applies the arbitration rules to this cycle's inputs.
  task automatic tick();
    int ng, ngv, nd, ndv, nrr, nlk, c;
    bit held, xfer;
    ng = mg; ngv = mgv; nd = md; ndv = mdv; nrr = mrr; nlk = mlk;
    if (s_ready) begin
      xfer = mgv && a_sel[mg] && a_trans[mg][1];
      ndv = xfer;
      if (xfer) nd = mg;
      nlk = mgv && a_lock[mg];
      held = mgv && !(s_resp && mdv) &&
             (a_trans[mg] == 2'b11 || a_trans[mg] == 2'b01 ||
              (a_trans[mg] == 2'b10 && a_burst[mg] != 3'b000) || a_lock[mg] || mlk != 0);
      if (!held) begin
        ngv = 0;
        for (int k = 0; k < NM; k++) begin
          c = (mrr + k) % NM;
          if (ngv == 0 && wants(c)) begin
            ngv = 1; ng = c; nrr = (c + 1) % NM;
          end
        end
      end
    end
    @(posedge clk);
    if (rst_ni) begin
      mg = ng; mgv = ngv; md = nd; mdv = ndv; mrr = nrr; mlk = nlk;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_s_hsel", s_hsel, 1'b0);
    chk("rst_s_htrans", s_htrans, 2'b00);
    chk("rst_m_hready", m_hready, 2'b11);
    chk("rst_m_hresp", m_hresp, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    bit found;
    idle_all();
    model_reset();

    // single master write
    do_reset();
    set_m(0, 1, 2'b10, 3'b000, 0, 1, 32'h100, 32'h0);
    settle(); chk("single_c1_stall", m_hready[0], 1'b0); tick();
    settle(); chk("single_c2_addr", s_haddr, 32'h100); chk("single_c2_rdy", m_hready, 2'b11); tick();
    set_m(0, 0, 2'b00, 3'b000, 0, 1, 32'h0, 32'hDEADBEEF);
    settle(); chk("single_c3_wdata", s_hwdata, 32'hDEADBEEF); chk("single_m1_rdy", m_hready[1], 1'b1); tick();

    // contention, pointer at 0
    do_reset();
    set_m(0, 1, 2'b10, 3'b000, 0, 1, 32'h110, 32'h0);
    set_m(1, 1, 2'b10, 3'b000, 0, 1, 32'h210, 32'h0);
    settle(); chk("cont_c1_both_stall", m_hready, 2'b00); tick();
    settle(); chk("cont_m0_first", s_haddr, 32'h110); chk("cont_m1_stall", m_hready[1], 1'b0); tick();
    set_m(0, 0, 2'b00, 3'b000, 0, 1, 32'h0, 32'h11);
    settle(); chk("cont_m1_next", s_haddr, 32'h210); chk("cont_m1_rdy", m_hready[1], 1'b1); tick();
    set_m(1, 0, 2'b00, 3'b000, 0, 1, 32'h0, 32'h22);
    settle(); tick();

    // burst hold
    do_reset();
    set_m(1, 1, 2'b10, 3'b000, 0, 0, 32'h300, 32'h0);
    set_m(0, 1, 2'b10, 3'b011, 0, 1, 32'h200, 32'h0);
    settle(); tick();
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1, (k == 0) ? 2'b10 : 2'b11, 3'b011, 0, 1, 32'h200 + 32'(4 * k), 32'(k));
      settle();
      chk("burst_beat_addr", s_haddr, 32'h200 + 32'(4 * k));
      chk("burst_m1_stall", m_hready[1], 1'b0);
      tick();
    end
    set_m(0, 0, 2'b00, 3'b000, 0, 1, 32'h0, 32'h3);
    found = 0;
    for (int n = 0; n < 6 && !found; n++) begin
      settle();
      if (s_htrans == 2'b10 && s_haddr == 32'h300) found = 1;
      tick();
    end
    chk("burst_m1_granted", found, 1'b1);
    set_m(1, 0, 2'b00, 3'b000, 0, 0, 32'h0, 32'h0);
    settle(); tick();

    // locked sequence
    do_reset();
    set_m(1, 1, 2'b10, 3'b000, 1, 1, 32'h400, 32'h0);
    settle(); tick();
    set_m(0, 1, 2'b10, 3'b000, 0, 1, 32'h500, 32'h0);
    settle(); chk("lock_first", s_haddr, 32'h400); chk("lock_m0_stall1", m_hready[0], 1'b0); tick();
    set_m(1, 1, 2'b10, 3'b000, 1, 1, 32'h404, 32'hA1);
    settle(); chk("lock_second", s_haddr, 32'h404); chk("lock_flag", s_hmastlock, 1'b1);
    chk("lock_m0_stall2", m_hready[0], 1'b0); tick();
    set_m(1, 0, 2'b00, 3'b000, 0, 1, 32'h0, 32'hA2);
    found = 0;
    for (int n = 0; n < 6 && !found; n++) begin
      settle();
      if (s_htrans == 2'b10 && s_haddr == 32'h500) found = 1;
      tick();
    end
    chk("lock_m0_after", found, 1'b1);
    set_m(0, 0, 2'b00, 3'b000, 0, 1, 32'h0, 32'h0);
    settle(); tick();

    // wait states then two-cycle ERROR on M0's read, then M1 read
    do_reset();
    set_m(0, 1, 2'b10, 3'b000, 0, 0, 32'h600, 32'h0);
    settle(); tick();
    settle(); chk("err_m0_addr", s_haddr, 32'h600); tick();
    set_m(0, 0, 2'b00, 3'b000, 0, 0, 32'h0, 32'h0);
    set_m(1, 1, 2'b10, 3'b000, 0, 0, 32'h700, 32'h0);
    s_ready = 0;
    settle(); chk("err_wait1", m_hready, 2'b00); tick();
    settle(); chk("err_wait2", m_hready, 2'b00); tick();
    s_resp = 1;
    settle(); chk("err_cycle1_resp", m_hresp, 2'b01); tick();
    s_ready = 1;
    settle(); chk("err_cycle2_resp", m_hresp, 2'b01); tick();
    s_resp = 0;
    settle(); chk("err_m1_addr", s_haddr, 32'h700); tick();
    set_m(1, 0, 2'b00, 3'b000, 0, 0, 32'h0, 32'h0);
    s_rdata = 32'h12345678;
    settle(); chk("err_m1_rdata", m_hrdata[63:32], 32'h12345678);
    chk("err_m1_rdy", m_hready[1], 1'b1); chk("err_m1_noresp", m_hresp, 2'b00); tick();

    // reset during beat 2 of a WRAP4
    do_reset();
    set_m(0, 1, 2'b10, 3'b010, 0, 1, 32'h800, 32'h0);
    settle(); tick();
    settle(); tick();
    set_m(0, 1, 2'b11, 3'b010, 0, 1, 32'h804, 32'h0);
    settle();
    #1;
    rst_ni = 1'b0;
    idle_all();
    model_reset();
    #1;
    chk("midrst_htrans", s_htrans, 2'b00);
    chk("midrst_hready", m_hready, 2'b11);
    chk("midrst_hsel", s_hsel, 1'b0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    set_m(0, 1, 2'b10, 3'b000, 0, 1, 32'hA00, 32'h0);
    set_m(1, 1, 2'b10, 3'b000, 0, 1, 32'hB00, 32'h0);
    settle(); tick();
    settle(); chk("midrst_first_m0", s_haddr, 32'hA00); tick();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NM; i++) begin
        a_sel[i]   = ($urandom_range(0, 3) != 0);
        a_trans[i] = 2'($urandom_range(0, 3));
        a_burst[i] = 3'($urandom_range(0, 7));
        a_size[i]  = 3'($urandom_range(0, 2));
        a_prot[i]  = 4'($urandom_range(0, 15));
        a_lock[i]  = ($urandom_range(0, 7) == 0);
        a_write[i] = ($urandom_range(0, 1) == 1);
        a_addr[i]  = $urandom;
        a_wdata[i] = $urandom;
      end
      s_ready = ($urandom_range(0, 3) != 0);
      s_resp  = ($urandom_range(0, 9) == 0);
      s_rdata = $urandom;
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
